// File: rtl/acl_presets_pkg.sv
// Shared definitions for the threshold-preset applier.
// Holds the applier state encoding, the default accelerometer register
// addresses and the 11-bit threshold ceiling, plus the clamp helper.
package acl_presets_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE
  } t_applier_state;

  localparam logic [7:0]  c_addr_thresh_l = 8'h20;
  localparam logic [7:0]  c_addr_thresh_h = 8'h21;
  localparam logic [7:0]  c_addr_timer_l  = 8'h25;
  localparam logic [7:0]  c_addr_timer_h  = 8'h26;
  localparam logic [10:0] c_thresh_max    = 11'd2047;

  // The activity-threshold register is only 11 bits wide; larger presets saturate.
  function automatic logic [10:0] clamp_thresh(input logic [15:0] thr);
    logic [10:0] res;
    if (thr > {5'b0, c_thresh_max}) res = c_thresh_max;
    else                            res = thr[10:0];
    return res;
  endfunction

endpackage

// File: rtl/preset_change_detect.sv
// Preset change detector.
// Keeps a one-cycle-delayed shadow of the preset bus and raises `pending`
// whenever the live bus differs from it. `pending` comes out of reset set so
// the applier always programs the sensor once after start-up.
//   clk, rst_n         : clock, asynchronous active-low reset
//   value_enum/thresh/timer : live preset bus
//   clr                : applier has latched the bus (clears pending)
//   set_retry          : applier aborted a sequence (forces pending)
//   pending            : an application is owed
module preset_change_detect
  import acl_presets_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  value_enum,
  input  logic [15:0] value_thresh,
  input  logic [15:0] value_timer,
  input  logic        clr,
  input  logic        set_retry,
  output logic        pending
);

  logic [3:0]  shadow_enum;
  logic [15:0] shadow_thresh;
  logic [15:0] shadow_timer;
  logic        changed;

  assign changed = {value_enum, value_thresh, value_timer} !=
                   {shadow_enum, shadow_thresh, shadow_timer};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_enum   <= '0;
      shadow_thresh <= '0;
      shadow_timer  <= '0;
      pending       <= 1'b1;
    end else begin
      shadow_enum   <= value_enum;
      shadow_thresh <= value_thresh;
      shadow_timer  <= value_timer;
      // A change seen on the latch cycle must survive the clear.
      if (changed || set_retry) pending <= 1'b1;
      else if (clr)             pending <= 1'b0;
    end
  end

endmodule

// File: rtl/thresh_presets_applier.sv
// Threshold-preset applier.
// On start-up and on every preset change, writes the activity threshold
// (two bytes, clamped to 11 bits) and inactivity timer (two bytes) into the
// accelerometer through the SPI register-write driver's req/ack handshake.
//   i_clk_20mhz, i_rst_20mhz_n : clock, asynchronous active-low reset
//   i_value_enum/thresh/timer  : active preset from the selector
//   o_wr_req/addr/data, i_wr_ack : register-write handshake
//   o_busy         : sequence in progress
//   o_applied_enum : enum of the last fully applied preset
//   o_done         : one-cycle pulse on sequence completion
//   o_err          : one-cycle pulse on ack timeout (sequence is retried)
//   o_clamped      : latched threshold exceeded the 11-bit ceiling
module thresh_presets_applier
  import acl_presets_pkg::*;
#(
  parameter logic [7:0]  parm_addr_thresh_l = c_addr_thresh_l,
  parameter logic [7:0]  parm_addr_thresh_h = c_addr_thresh_h,
  parameter logic [7:0]  parm_addr_timer_l  = c_addr_timer_l,
  parameter logic [7:0]  parm_addr_timer_h  = c_addr_timer_h,
  parameter logic [15:0] parm_ack_timeout   = 16'd2000
) (
  input  logic        i_clk_20mhz,
  input  logic        i_rst_20mhz_n,
  input  logic [3:0]  i_value_enum,
  input  logic [15:0] i_value_thresh,
  input  logic [15:0] i_value_timer,
  output logic        o_wr_req,
  output logic [7:0]  o_wr_addr,
  output logic [7:0]  o_wr_data,
  input  logic        i_wr_ack,
  output logic        o_busy,
  output logic [3:0]  o_applied_enum,
  output logic        o_done,
  output logic        o_err,
  output logic        o_clamped
);

  t_applier_state state, next_state;
  logic        pending;
  logic        latch, accept, timeout;
  logic [3:0]  w_enum;
  logic [10:0] w_thr;
  logic [15:0] w_tmr;
  logic [1:0]  idx;
  logic [15:0] cnt;
  logic [7:0]  byte_addr, byte_data;

  preset_change_detect u_detect (
    .clk          (i_clk_20mhz),
    .rst_n        (i_rst_20mhz_n),
    .value_enum   (i_value_enum),
    .value_thresh (i_value_thresh),
    .value_timer  (i_value_timer),
    .clr          (latch),
    .set_retry    (timeout),
    .pending      (pending)
  );

  always_comb begin : fsm_next
    next_state = state;
    latch      = 1'b0;
    accept     = 1'b0;
    timeout    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pending) begin
          latch      = 1'b1;
          next_state = ST_ISSUE;
        end
      end
      ST_ISSUE: next_state = ST_WAIT;
      ST_WAIT: begin
        // An ack on the final timeout cycle still wins.
        if (i_wr_ack) begin
          accept     = 1'b1;
          next_state = (idx == 2'd3) ? ST_DONE : ST_ISSUE;
        end else if (cnt == parm_ack_timeout) begin
          timeout    = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_comb begin : byte_mux
    byte_addr = parm_addr_thresh_l;
    byte_data = w_thr[7:0];
    case (idx)
      2'd1: begin
        byte_addr = parm_addr_thresh_h;
        byte_data = {5'b0, w_thr[10:8]};
      end
      2'd2: begin
        byte_addr = parm_addr_timer_l;
        byte_data = w_tmr[7:0];
      end
      2'd3: begin
        byte_addr = parm_addr_timer_h;
        byte_data = w_tmr[15:8];
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) state <= ST_IDLE;
    else                state <= next_state;
  end

  always_ff @(posedge i_clk_20mhz or negedge i_rst_20mhz_n) begin
    if (!i_rst_20mhz_n) begin
      w_enum         <= '0;
      w_thr          <= '0;
      w_tmr          <= '0;
      idx            <= '0;
      cnt            <= '0;
      o_wr_req       <= 1'b0;
      o_wr_addr      <= '0;
      o_wr_data      <= '0;
      o_applied_enum <= '0;
      o_err          <= 1'b0;
      o_clamped      <= 1'b0;
    end else begin
      o_err <= timeout;
      if (latch) begin
        w_enum    <= i_value_enum;
        w_thr     <= clamp_thresh(i_value_thresh);
        w_tmr     <= i_value_timer;
        o_clamped <= i_value_thresh > {5'b0, c_thresh_max};
        idx       <= '0;
      end
      // Request is registered: it rises as ST_WAIT is entered and stays
      // stable for the whole wait.
      if (state == ST_ISSUE) begin
        o_wr_req  <= 1'b1;
        o_wr_addr <= byte_addr;
        o_wr_data <= byte_data;
        cnt       <= '0;
      end
      if (state == ST_WAIT && !accept && !timeout) cnt <= cnt + 16'd1;
      if (accept || timeout) o_wr_req <= 1'b0;
      if (accept && idx != 2'd3) idx <= idx + 2'd1;
      if (state == ST_DONE) o_applied_enum <= w_enum;
    end
  end

  assign o_busy = (state != ST_IDLE);
  assign o_done = (state == ST_DONE);

endmodule
